// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART receive-side packet controller.
// Holds the frame sync byte, the payload size limit, the error codes
// reported on o_ERR_CODE and the FSM state encoding.
// No ports (package).
package uart_pkt_pkg;

  localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
  localparam int         c_MAX_LEN   = 8;

  localparam logic [1:0] c_ERR_CHK     = 2'd1;
  localparam logic [1:0] c_ERR_LEN     = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter for the packet controller.
// Ports:
//   i_CLK      system clock
//   i_RESET    synchronous active-high reset
//   i_CLEAR    forces the count to zero (a byte arrived, or the FSM is idle)
//   i_ENABLE   counts one per clock while high and not cleared
//   o_EXPIRED  high on the cycle whose increment reaches c_TIMEOUT_CYCLES,
//              so the registered error in the parent lands exactly then
module uart_rx_timeout #(
  parameter int c_TIMEOUT_CYCLES = 8680
) (
  input  logic i_CLK,
  input  logic i_RESET,
  input  logic i_CLEAR,
  input  logic i_ENABLE,
  output logic o_EXPIRED
);

  localparam logic [15:0] c_LAST = 16'(c_TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge i_CLK) begin
    if (i_RESET || i_CLEAR) begin
      count <= '0;
    end else if (i_ENABLE) begin
      count <= count + 16'd1;
    end
  end

  // A clear on the same cycle means a byte won the race against expiry.
  assign o_EXPIRED = i_ENABLE && !i_CLEAR && (count == c_LAST);

endmodule

// File: rtl/uart_packet_ctrl.sv
// Frames the UART receiver byte stream into packets:
//   0xA5, CMD, LEN, LEN payload bytes, CHK (CHK = CMD ^ LEN ^ payload).
// Verified packets are presented with a one-cycle o_PKT_VALID pulse;
// malformed or stalled packets are dropped with a one-cycle o_ERR pulse.
// Ports:
//   i_CLK, i_RESET         clock, synchronous active-high reset
//   i_RX_BYTE, i_RX_DV     byte and one-cycle valid from the UART receiver
//   o_PKT_VALID            packet verified (fields held until next pulse)
//   o_PKT_CMD/LEN/DATA     command, length 0..8, payload (byte k at [8k+7:8k])
//   o_ERR, o_ERR_CODE      discard pulse; code 1=checksum 2=length 3=timeout
//   o_BUSY                 high while a packet is being framed
module uart_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int c_TIMEOUT_CYCLES = 8680,
  parameter int c_MAX_LEN        = 8
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [7:0]  i_RX_BYTE,
  input  logic        i_RX_DV,
  output logic        o_PKT_VALID,
  output logic [7:0]  o_PKT_CMD,
  output logic [3:0]  o_PKT_LEN,
  output logic [63:0] o_PKT_DATA,
  output logic        o_ERR,
  output logic [1:0]  o_ERR_CODE,
  output logic        o_BUSY
);

  localparam logic [7:0] c_MAX_LEN_BYTE = 8'(c_MAX_LEN);

  logic [2:0]  state;
  logic [7:0]  cmd_sh;
  logic [3:0]  len_sh;
  logic [63:0] data_sh;
  logic [7:0]  chk;
  logic [2:0]  idx;
  logic        expired;
  logic        tmo_clear;
  logic        tmo_enable;

  assign tmo_clear  = i_RX_DV || (state == S_IDLE);
  assign tmo_enable = (state != S_IDLE);

  uart_rx_timeout #(
    .c_TIMEOUT_CYCLES(c_TIMEOUT_CYCLES)
  ) u_timeout (
    .i_CLK     (i_CLK),
    .i_RESET   (i_RESET),
    .i_CLEAR   (tmo_clear),
    .i_ENABLE  (tmo_enable),
    .o_EXPIRED (expired)
  );

  // Busy is decoded from the state register only, so it stays glitch-free.
  assign o_BUSY = (state != S_IDLE);

  // Framing FSM. Payload is assembled in a shadow register and copied to
  // the outputs only when the checksum matches, so errors never disturb
  // the last good packet. A byte always takes priority over expiry.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state       <= S_IDLE;
      cmd_sh      <= '0;
      len_sh      <= '0;
      data_sh     <= '0;
      chk         <= '0;
      idx         <= '0;
      o_PKT_VALID <= 1'b0;
      o_PKT_CMD   <= '0;
      o_PKT_LEN   <= '0;
      o_PKT_DATA  <= '0;
      o_ERR       <= 1'b0;
      o_ERR_CODE  <= '0;
    end else begin
      o_PKT_VALID <= 1'b0;
      o_ERR       <= 1'b0;
      if (i_RX_DV) begin
        case (state)
          S_IDLE: begin
            if (i_RX_BYTE == c_SYNC_BYTE) begin
              data_sh <= '0;
              state   <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_sh <= i_RX_BYTE;
            chk    <= i_RX_BYTE;
            state  <= S_LEN;
          end
          S_LEN: begin
            if (i_RX_BYTE > c_MAX_LEN_BYTE) begin
              o_ERR      <= 1'b1;
              o_ERR_CODE <= c_ERR_LEN;
              state      <= S_IDLE;
            end else begin
              len_sh <= i_RX_BYTE[3:0];
              chk    <= chk ^ i_RX_BYTE;
              idx    <= '0;
              state  <= (i_RX_BYTE == 8'd0) ? S_CHECK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            data_sh[{idx, 3'b000} +: 8] <= i_RX_BYTE;
            chk <= chk ^ i_RX_BYTE;
            idx <= idx + 3'd1;
            if (idx == 3'(len_sh - 4'd1)) begin
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (i_RX_BYTE == chk) begin
              o_PKT_VALID <= 1'b1;
              o_PKT_CMD   <= cmd_sh;
              o_PKT_LEN   <= len_sh;
              o_PKT_DATA  <= data_sh;
            end else begin
              o_ERR      <= 1'b1;
              o_ERR_CODE <= c_ERR_CHK;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (expired) begin
        o_ERR      <= 1'b1;
        o_ERR_CODE <= c_ERR_TIMEOUT;
        state      <= S_IDLE;
      end
    end
  end

endmodule
